// File: rtl/div_radix2_early_exit_pkg.sv
// Shared types for the division core: the sequencer state encoding.
package taiga_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    DONE   = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_radix2_early_exit_clz.sv
// Combinational leading-zero counter; an all-zero input reports W.
module div_clz #(
  parameter int W  = 32,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  value,
  output logic [CW-1:0] count
);

  // Later (higher) set bits overwrite earlier ones, so the MSB-most one wins.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (value[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/div_radix2_early_exit.sv
// Radix-2 restoring divider that skips the dividend's leading zeros, so a
// division takes one cycle per significant dividend bit.
//
// state  | meaning
// IDLE   | waiting for start; results from the last division held
// DIVIDE | one quotient bit per edge, counter counts down to the last bit
// DONE   | done pulse; start here begins the next division back-to-back
module div_radix2_early_exit
  import taiga_types::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  divisor_is_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;

  div_state_t     state, state_nxt;
  logic [W-1:0]   q_reg, r_reg, dvd_sh, dvs;
  logic           dz_reg;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  lz, n_iter;
  logic           accept, last_iter, trivial;
  logic [W:0]     trial, diff;
  logic           ge;

  div_clz #(.W(W), .CW(CW)) u_clz (
    .value (dividend),
    .count (lz)
  );

  assign n_iter    = CW'(W) - lz;
  assign accept    = start && (state == IDLE || state == DONE);
  assign trivial   = (divisor == '0) || (dividend == '0);
  assign last_iter = (cnt == CW'(1));

  assign trial = {r_reg, dvd_sh[W-1]};
  assign diff  = trial - {1'b0, dvs};
  assign ge    = (trial >= {1'b0, dvs});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = trivial ? DONE : DIVIDE;
      end
      DIVIDE: begin
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = trivial ? DONE : DIVIDE;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= '0;
      r_reg  <= '0;
      dvd_sh <= '0;
      dvs    <= '0;
      dz_reg <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      dvs    <= divisor;
      dz_reg <= (divisor == '0);
      dvd_sh <= dividend << lz;
      cnt    <= n_iter;
      if (divisor == '0) begin
        q_reg <= '1;
        r_reg <= dividend;
      end else begin
        q_reg <= '0;
        r_reg <= '0;
      end
    end else if (state == DIVIDE) begin
      // Quotient and remainder both fit W bits once the trial is resolved.
      r_reg  <= ge ? diff[W-1:0] : trial[W-1:0];
      q_reg  <= {q_reg[W-2:0], ge};
      dvd_sh <= dvd_sh << 1;
      cnt    <= cnt - CW'(1);
    end
  end

  assign quotient        = q_reg;
  assign remainder       = r_reg;
  assign divisor_is_zero = dz_reg;

endmodule

// File: tb/tb_div_radix2_early_exit.sv
// Directed and randomized checks of the early-exit divider against plain arithmetic.
module tb_div_radix2_early_exit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend, divisor;
  logic        done;
  logic [31:0] quotient, remainder;
  logic        divisor_is_zero;

  int vectors = 0;
  int errors  = 0;

  div_radix2_early_exit #(.DATA_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder),
    .divisor_is_zero (divisor_is_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sig_bits(input logic [31:0] v);
    int n = 0;
    logic [31:0] t = v;
    while (t != 0) begin
      n++;
      t = t >> 1;
    end
    return n;
  endfunction

  function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
    if (a == 0 || b == 0) return 1;
    return 1 + sig_bits(a);
  endfunction

  // Drives start for one cycle (cycle T) and returns after the edge ending T.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts cycles after T until done is seen at a falling edge; bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b);
    int lat;
    logic [31:0] eq, er;
    if (b == 0) begin
      eq = 32'hFFFF_FFFF;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    issue(a, b);
    wait_done(lat);
    check({tag, " latency"}, 64'(lat), 64'(exp_latency(a, b)));
    check({tag, " quotient"}, {32'd0, quotient}, {32'd0, eq});
    check({tag, " remainder"}, {32'd0, remainder}, {32'd0, er});
    check({tag, " dz"}, {63'd0, divisor_is_zero}, {63'd0, (b == 0)});
    @(negedge clk);
    check({tag, " done single"}, {63'd0, done}, 64'd0);
    check({tag, " hold q"}, {32'd0, quotient}, {32'd0, eq});
  endtask

  initial begin
    int lat;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset q", {32'd0, quotient}, 64'd0);
    check("reset r", {32'd0, remainder}, 64'd0);
    check("reset dz", {63'd0, divisor_is_zero}, 64'd0);
    rst = 1'b0;

    run_div("100/7", 32'd100, 32'd7);
    run_div("max/1", 32'hFFFF_FFFF, 32'd1);
    run_div("5/0", 32'd5, 32'd0);
    run_div("0/9", 32'd0, 32'd9);
    run_div("0/0", 32'd0, 32'd0);

    // Back-to-back: second start in the done cycle of the first.
    issue(32'd3, 32'd10);
    wait_done(lat);
    check("b2b first latency", 64'(lat), 64'd3);
    check("b2b first q", {32'd0, quotient}, 64'd0);
    check("b2b first r", {32'd0, remainder}, 64'd3);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k < 7) check("b2b no early done", {63'd0, done}, 64'd0);
      else       check("b2b second done", {63'd0, done}, 64'd1);
      if (k == 2 || k == 4) begin
        start = 1'b1; dividend = 32'd999; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    check("b2b second q", {32'd0, quotient}, 64'd10);
    check("b2b second r", {32'd0, remainder}, 64'd0);
    @(negedge clk);
    check("b2b back idle", {63'd0, done}, 64'd0);

    // Reset in the middle of a full-length divide.
    issue(32'hFFFF_FFFF, 32'd3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid q", {32'd0, quotient}, 64'd0);
    check("rst mid r", {32'd0, remainder}, 64'd0);
    check("rst mid dz", {63'd0, divisor_is_zero}, 64'd0);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      if (done === 1'b1) lat++;
      @(negedge clk);
    end
    check("rst mid no done", 64'(lat), 64'd0);
    run_div("post-rst 100/7", 32'd100, 32'd7);

    for (int i = 0; i < 40; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = $urandom;
        default: b = $urandom >> $urandom_range(8, 31);
      endcase
      if ($urandom_range(0, 9) == 0) a = 32'd0;
      run_div("rand", a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/div_radix2_early_exit.md
DIV_RADIX2_EARLY_EXIT -- requirements
Module: div_radix2_early_exit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the operand and result width W.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE or in the done cycle.
REQ-005 SHALL have port dividend  input  W  unsigned dividend; valid only in the start cycle.
REQ-006 SHALL have port divisor  input  W  unsigned divisor; valid only in the start cycle.
REQ-007 SHALL have port done  output  1  single-cycle completion pulse.
REQ-008 SHALL have port quotient  output  W  unsigned quotient; stable from done until the next accepted start.
REQ-009 SHALL have port remainder  output  W  unsigned remainder; stable from done until the next accepted start.
REQ-010 SHALL have port divisor_is_zero  output  1  set when the latched divisor is 0; stable from done until the next accepted start.

Function
REQ-011 SHALL implement states IDLE, DIVIDE and DONE, held in a state register.
REQ-012 SHALL, on an accepted start, latch divisor and compute divisor_is_zero.
REQ-013 SHALL, on an accepted start, compute c = count of leading zeros of dividend and N = W - c.
REQ-014 SHALL, on an accepted start, load the dividend shifted left by c, load iteration counter N, and clear the partial remainder and quotient.
REQ-015 SHALL take IDLE->DIVIDE on an accepted start when divisor != 0 and dividend != 0.
REQ-016 SHALL take IDLE->DONE in one edge when divisor == 0 (quotient = all ones, remainder = dividend, divisor_is_zero = 1).
REQ-017 SHALL take IDLE->DONE in one edge when dividend == 0 and divisor != 0 (quotient = 0, remainder = 0).
REQ-018 SHALL, per DIVIDE edge, form a W+1-bit trial value R' = {R, msb of shifted dividend}.
REQ-019 SHALL, per DIVIDE edge, set R = R' - divisor with quotient bit 1 when R' >= divisor, else R = R' with quotient bit 0.
REQ-020 SHALL, per DIVIDE edge, shift the quotient left by 1 inserting the new bit, shift the dividend left by 1, and decrement the counter.
REQ-021 SHALL take DIVIDE->DONE on the edge that performs the last (Nth) iteration.
REQ-022 SHALL assert done only in DONE, combinationally from state, for exactly one cycle.
REQ-023 SHALL take DONE->IDLE, or DONE->DIVIDE/DONE when start is asserted in that cycle (back-to-back accept).
REQ-024 SHALL give latency, with start high in cycle T: done in cycle T+1 for the REQ-016/017 cases, otherwise in cycle T+1+N; maximum T+1+W.
REQ-025 SHALL ignore start while in DIVIDE, with no effect on state or results.
REQ-026 SHALL leave quotient, remainder and divisor_is_zero unchanged in IDLE until the next accepted start.

Reset
REQ-027 SHALL, on rst, enter IDLE, drive done=0, clear quotient, remainder and divisor_is_zero to 0, and clear the counter.
REQ-028 SHALL, on rst during DIVIDE or DONE, abandon the operation and produce no done pulse.
REQ-029 SHALL give rst priority over start in the same cycle.

Structure
REQ-030 SHALL define the state enum type div_state_t in the shared taiga_types package.
REQ-031 SHALL place the leading-zero counter in one sub-module, div_clz (W-bit input, clog2(W)+1-bit count, combinational).
REQ-032 SHALL size the counter at clog2(W)+1 bits to hold N = W.
REQ-033 SHALL act as the division core beneath div_unit and honour that unit's start/done contract.

Verification
REQ-034 SHALL pass: start, 100 / 7 -> quotient 14, remainder 2, divisor_is_zero 0, done at T+8 (N=7).
REQ-035 SHALL pass: start, 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0, done at T+33.
REQ-036 SHALL pass: start, 5 / 0 -> divisor_is_zero 1, quotient 0xFFFFFFFF, remainder 5, done at T+1.
REQ-037 SHALL pass: start, 0 / 9 -> quotient 0, remainder 0, done at T+1.
REQ-038 SHALL pass: start 3 / 10, then start 50 / 5 in the done cycle of the first -> first quotient 0, remainder 3, done T+3; second quotient 10, remainder 0, done 7 cycles later; start pulses during DIVIDE ignored.
REQ-039 SHALL pass: rst at T+4 of a 32-iteration divide -> IDLE, outputs 0, no done; next start 100 / 7 -> quotient 14, remainder 2.
